pixel_update_scheduler: RTL and testbench
=========================================

PIXEL_UPDATE_SCHEDULER -- requirements
Module: pixel_update_scheduler

Interface
REQ-001 Parameter: DEPTH, 8, number of queued cell updates (power of two, 2..16).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 push  input  1  game logic requests one cell update this cycle.
REQ-005 push_x  input  4  cell column of pushed update.
REQ-006 push_y  input  4  cell row of pushed update.
REQ-007 push_obj  input  3  object code of pushed update.
REQ-008 cmd_done  input  1  single-cycle completion pulse from pixel_updater.
REQ-009 init_cycle  output  1  display-initialisation request to pixel_updater.
REQ-010 en_update  output  1  cell-draw request to pixel_updater.
REQ-011 x  output  4  column of cell being drawn.
REQ-012 y  output  4  row of cell being drawn.
REQ-013 obj_code  output  3  object code of cell being drawn.
REQ-014 ready  output  1  display initialisation complete.
REQ-015 full  output  1  queue holds DEPTH entries.
REQ-016 pending  output  5  number of queued entries, 0..DEPTH.
REQ-017 overflow  output  1  sticky flag: a push was dropped.

Function
REQ-018 States SHALL be INIT_REQ, IDLE, UPDATE; all outputs SHALL be registered.
REQ-019 INIT_REQ: init_cycle=1; cmd_done sampled high -> init_cycle=0, ready=1, state IDLE on that edge.
REQ-020 IDLE with pending>0: on next edge load x/y/obj_code from queue head, en_update=1, state UPDATE.
REQ-021 IDLE with pending=0: stay IDLE, en_update=0, x/y/obj_code hold last values.
REQ-022 UPDATE: cmd_done sampled high -> en_update=0, head entry popped, state IDLE on that edge.
REQ-023 en_update SHALL be low for at least one cycle between consecutive draw requests.
REQ-024 x, y, obj_code SHALL be stable for the whole time en_update is high.
REQ-025 cmd_done in IDLE, or on the edge that leaves IDLE, SHALL be ignored.
REQ-026 Queue SHALL be FIFO-ordered; entries drain strictly in push order.
REQ-027 Push with pending<DEPTH SHALL be written on the same edge; pending increments.
REQ-028 Push with full=1 and no simultaneous pop SHALL be dropped and set overflow.
REQ-029 Push and pop on the same edge SHALL both take effect; pending unchanged, including when full.
REQ-030 Pushes during INIT_REQ SHALL be accepted and held until ready=1.
REQ-031 full SHALL equal (pending==DEPTH); pointers SHALL wrap modulo DEPTH.
REQ-032 Latency: push into empty queue in IDLE at edge P -> en_update high after edge P+1.

Reset
REQ-033 rst sampled high SHALL clear queue, pointers, pending, full, overflow, ready, init_cycle, en_update, x, y, obj_code to 0 and set state INIT_REQ.
REQ-034 init_cycle SHALL rise on the first edge at which rst is sampled low.
REQ-035 rst mid-UPDATE or mid-INIT_REQ SHALL abandon the request and discard all queued entries; initialisation SHALL re-run.
REQ-036 overflow SHALL clear only on rst.

Verification
REQ-037 Reset release -> init_cycle=1 one edge later; ready=0, en_update=0 until cmd_done pulse; then init_cycle=0, ready=1.
REQ-038 After ready, push (4,4,3'b001) -> next edge en_update=1, x=4, y=4, obj_code=1; cmd_done -> en_update=0, pending=0.
REQ-039 Push 3 entries during INIT_REQ -> none drawn before ready; then drawn in push order, en_update low >=1 cycle between each.
REQ-040 Fill DEPTH=8 entries, push a 9th -> dropped, overflow=1, full=1, pending=8; push coinciding with cmd_done pop when full -> accepted, pending stays 8.
REQ-041 Assert rst while en_update=1 with 5 pending -> all outputs 0, pending=0, init_cycle re-asserts after rst release.
REQ-042 Spurious cmd_done in IDLE with pending=0 -> no state change, no pop, outputs unchanged.

Source files
------------

// File: rtl/pixel_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pixel_update_scheduler
// Brief    : Queues cell updates from game logic and issues one
//            display-init request, then one draw request at a time,
//            to pixel_updater.
// Revision : 1.0
// ============================================================================
module pixel_update_scheduler #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [3:0] push_x,
  input  logic [3:0] push_y,
  input  logic [2:0] push_obj,
  input  logic       cmd_done,
  output logic       init_cycle,
  output logic       en_update,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [2:0] obj_code,
  output logic       ready,
  output logic       full,
  output logic [4:0] pending,
  output logic       overflow
);

  localparam int         c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] c_DEPTH = 5'(DEPTH);

  typedef enum logic [1:0] {
    INIT_REQ = 2'd0,
    IDLE     = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [10:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [4:0]         r_pending;
  logic               r_full;
  logic               r_overflow;
  logic               r_init;
  logic               r_ready;
  logic               r_en;
  logic [3:0]         r_x;
  logic [3:0]         r_y;
  logic [2:0]         r_obj;

  logic       w_init_nxt;
  logic       w_ready_nxt;
  logic       w_en_nxt;
  logic       w_load;
  logic       w_pop;
  logic       w_wr;
  logic       w_drop;
  logic [4:0] w_pend_nxt;

  // A full queue still accepts a push when the head leaves on the same edge.
  assign w_pop  = (r_state == UPDATE) && cmd_done;
  assign w_wr   = push && (!r_full || w_pop);
  assign w_drop = push && r_full && !w_pop;

  always_comb begin
    w_pend_nxt = r_pending;
    case ({w_wr, w_pop})
      2'b10:   w_pend_nxt = r_pending + 5'd1;
      2'b01:   w_pend_nxt = r_pending - 5'd1;
      default: w_pend_nxt = r_pending;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_nxt  = r_init;
    w_ready_nxt = r_ready;
    w_en_nxt    = r_en;
    w_load      = 1'b0;
    case (r_state)
      INIT_REQ: begin
        // First edge out of reset raises the request; completion only counts once it is up.
        if (!r_init) begin
          w_init_nxt = 1'b1;
        end else if (cmd_done) begin
          w_init_nxt  = 1'b0;
          w_ready_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (r_pending != 5'd0) begin
          w_load      = 1'b1;
          w_en_nxt    = 1'b1;
          w_state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        if (cmd_done) begin
          w_en_nxt    = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = INIT_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pending  <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_init     <= 1'b0;
      r_ready    <= 1'b0;
      r_en       <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_obj      <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {push_x, push_y, push_obj};
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_load) begin
        {r_x, r_y, r_obj} <= r_mem[r_rd_ptr];
      end
      r_pending <= w_pend_nxt;
      r_full    <= (w_pend_nxt == c_DEPTH);
      r_init    <= w_init_nxt;
      r_ready   <= w_ready_nxt;
      r_en      <= w_en_nxt;
    end
  end

  assign init_cycle = r_init;
  assign en_update  = r_en;
  assign x          = r_x;
  assign y          = r_y;
  assign obj_code   = r_obj;
  assign ready      = r_ready;
  assign full       = r_full;
  assign pending    = r_pending;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pixel_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_update_scheduler
// Brief    : Scoreboard bench for pixel_update_scheduler (DEPTH = 8).
// Revision : 1.0
// ============================================================================
module tb_pixel_update_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic [3:0] push_x = '0;
  logic [3:0] push_y = '0;
  logic [2:0] push_obj = '0;
  logic       cmd_done = 1'b0;
  logic       init_cycle, en_update, ready, full, overflow;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic [4:0] pending;

  typedef struct packed {
    logic [3:0] ex;
    logic [3:0] ey;
    logic [2:0] eo;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic       prev_en = 1'b0;
  logic [3:0] prev_x = '0;
  logic [3:0] prev_y = '0;
  logic [2:0] prev_o = '0;

  pixel_update_scheduler #(.DEPTH(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_x     (push_x),
    .push_y     (push_y),
    .push_obj   (push_obj),
    .cmd_done   (cmd_done),
    .init_cycle (init_cycle),
    .en_update  (en_update),
    .x          (x),
    .y          (y),
    .obj_code   (obj_code),
    .ready      (ready),
    .full       (full),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each new draw request is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (en_update && !prev_en) begin
        if (sb.size() == 0) begin
          check("draw_unexpected", 32'd0, 32'd1);
        end else begin
          check("draw_x", 32'(x), 32'(sb[0].ex));
          check("draw_y", 32'(y), 32'(sb[0].ey));
          check("draw_obj", 32'(obj_code), 32'(sb[0].eo));
          sb.delete(0);
        end
      end else if (en_update && prev_en) begin
        check("stable_xyo", 32'({x, y, obj_code}), 32'({prev_x, prev_y, prev_o}));
      end
    end
    prev_en <= en_update && !rst;
    prev_x  <= x;
    prev_y  <= y;
    prev_o  <= obj_code;
  end

  task automatic do_push(input logic [3:0] px, input logic [3:0] py, input logic [2:0] po,
                         input logic with_done, input logic accept);
    push     = 1'b1;
    push_x   = px;
    push_y   = py;
    push_obj = po;
    cmd_done = with_done;
    if (accept) sb.push_back('{ex: px, ey: py, eo: po});
    @(posedge clk);
    #1;
    push     = 1'b0;
    cmd_done = 1'b0;
  endtask

  task automatic pulse_done();
    cmd_done = 1'b1;
    @(posedge clk);
    #1;
    cmd_done = 1'b0;
  endtask

  task automatic ack_draw();
    for (int i = 0; i < 20 && !en_update; i++) begin
      @(posedge clk);
      #1;
    end
    if (!en_update) begin
      check("draw_timeout", 32'd0, 32'd1);
    end else begin
      pulse_done();
      check("en_low_after_done", 32'(en_update), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_init", 32'(init_cycle), 32'd0);
    check("rst_en", 32'(en_update), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Init handshake with three entries queued before ready.
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("init_rise", 32'(init_cycle), 32'd1);
    do_push(4'd1, 4'd2, 3'd3, 1'b0, 1'b1);
    do_push(4'd5, 4'd6, 3'd7, 1'b0, 1'b1);
    do_push(4'd9, 4'd10, 3'd2, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("init_hold_pending", 32'(pending), 32'd3);
    check("init_hold_en", 32'(en_update), 32'd0);
    check("init_hold_ready", 32'(ready), 32'd0);
    pulse_done();
    check("init_done_init", 32'(init_cycle), 32'd0);
    check("init_done_ready", 32'(ready), 32'd1);
    check("init_done_en", 32'(en_update), 32'd0);
    repeat (3) ack_draw();
    @(posedge clk);
    #1;
    check("drain3_pending", 32'(pending), 32'd0);

    // Single push into empty queue: draw one edge after the push edge.
    do_push(4'd4, 4'd4, 3'd1, 1'b0, 1'b1);
    check("lat_not_yet", 32'(en_update), 32'd0);
    @(posedge clk);
    #1;
    check("lat_en", 32'(en_update), 32'd1);
    check("lat_xyo", 32'({x, y, obj_code}), 32'({4'd4, 4'd4, 3'd1}));
    pulse_done();
    check("single_en", 32'(en_update), 32'd0);
    check("single_pending", 32'(pending), 32'd0);

    // Spurious completion while idle and empty.
    pulse_done();
    @(posedge clk);
    #1;
    check("spur_en", 32'(en_update), 32'd0);
    check("spur_pending", 32'(pending), 32'd0);
    check("spur_xyo", 32'({x, y, obj_code}), 32'({4'd4, 4'd4, 3'd1}));
    check("spur_ready", 32'(ready), 32'd1);

    // Fill, overflow, then push with simultaneous pop while full.
    for (int i = 0; i < 8; i++) begin
      do_push(4'(i), 4'(15 - i), 3'(i), 1'b0, 1'b1);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_pending", 32'(pending), 32'd8);
    check("fill_no_ovf", 32'(overflow), 32'd0);
    do_push(4'd9, 4'd9, 3'd7, 1'b0, 1'b0);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_full", 32'(full), 32'd1);
    check("drop_pending", 32'(pending), 32'd8);
    check("pp_in_update", 32'(en_update), 32'd1);
    do_push(4'd10, 4'd11, 3'd5, 1'b1, 1'b1);
    check("pp_pending", 32'(pending), 32'd8);
    check("pp_full", 32'(full), 32'd1);
    check("pp_en", 32'(en_update), 32'd0);
    repeat (8) ack_draw();
    @(posedge clk);
    #1;
    check("drain8_pending", 32'(pending), 32'd0);
    check("drain8_full", 32'(full), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset while drawing with five entries queued.
    for (int i = 0; i < 5; i++) begin
      do_push(4'(i + 3), 4'(i + 7), 3'(i + 2), 1'b0, 1'b1);
    end
    for (int i = 0; i < 10 && !en_update; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_en", 32'(en_update), 32'd1);
    check("mid_pending", 32'(pending), 32'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    check("mrst_outs", 32'({init_cycle, en_update, ready, full, overflow}), 32'd0);
    check("mrst_xyo", 32'({x, y, obj_code}), 32'd0);
    check("mrst_pending", 32'(pending), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_init_rise", 32'(init_cycle), 32'd1);
    check("mrst_ready", 32'(ready), 32'd0);
    pulse_done();
    check("mrst_ready_up", 32'(ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mrst_no_draw", 32'(en_update), 32'd0);
    do_push(4'd15, 4'd14, 3'd6, 1'b0, 1'b1);
    ack_draw();
    @(posedge clk);
    #1;
    check("final_pending", 32'(pending), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
